// File: rtl/pcm_pkg.sv
// Shared PCM definitions: frame state encoding, default line timing and sync pattern.
// Used by the frame generator and the pcm_nrz receiver.
package pcm_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SYNC = 2'd1,
      DATA = 2'd2
   } pcm_state_e;

   localparam int unsigned CLKS_PER_BIT_DEF    = 200;
   localparam int unsigned WORDS_PER_FRAME_DEF = 128;
   localparam int unsigned SYNC_BITS           = 32;
   localparam logic [31:0] SYNC_WORD_DEF       = 32'h0579B7C0;
   localparam logic [7:0]  FILL_BYTE_DEF       = 8'h00;

   function automatic int unsigned frame_bits(input int unsigned words);
      return words * 8;
   endfunction

endpackage

// File: rtl/pcm_bit_timer.sv
// NRZ bit-period timer: free-runs 0..CLKS_PER_BIT-1 while run_i is high, held at 0 otherwise.
// bit_start marks the clk a new bit is launched, bit_end the last clk of that bit.
module pcm_bit_timer
   import pcm_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic run_i,
   output logic bit_start_c_o,
   output logic bit_end_c_o
);

   localparam int unsigned TW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

   logic [TW-1:0] count_q, count_d;

   assign bit_start_c_o = run_i && (count_q == '0);
   assign bit_end_c_o   = run_i && (count_q == LAST);

   always_comb begin
      count_d = '0;
      if (run_i && !bit_end_c_o) begin
         count_d = count_q + TW'(1);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/pcm_nrz_frame_gen.sv
// Framed NRZ PCM source: 32-bit sync word followed by data bytes, MSB first.
// Bytes arrive through a one-deep holding register; an empty register at a word boundary sends FILL_BYTE.
module pcm_nrz_frame_gen
   import pcm_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT    = CLKS_PER_BIT_DEF,
   parameter int unsigned WORDS_PER_FRAME = WORDS_PER_FRAME_DEF,
   parameter logic [31:0] SYNC_WORD       = SYNC_WORD_DEF,
   parameter logic [7:0]  FILL_BYTE       = FILL_BYTE_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic [7:0] in_data,
   input  logic       in_valid,
   output logic       in_ready,
   output logic       txd,
   output logic       frame_start,
   output logic [7:0] frame_count,
   output logic       underrun
);

   localparam int unsigned FRAME_BITS = frame_bits(WORDS_PER_FRAME);
   localparam int unsigned BCW        = $clog2(FRAME_BITS);

   pcm_state_e     state_q, state_d;
   logic [BCW-1:0] bit_cnt_q, bit_cnt_d;
   logic [31:0]    shift_q, shift_d;
   logic [7:0]     hold_q, hold_d;
   logic           hold_full_q, hold_full_d;
   logic           in_ready_q, in_ready_d;
   logic           txd_q, txd_d;
   logic           frame_start_q, frame_start_d;
   logic [7:0]     frame_count_q, frame_count_d;
   logic           underrun_q, underrun_d;

   logic       run_c, bit_start_c, bit_end_c;
   logic       accept_c, boundary_c, last_bit_c, last_sync_c;
   logic [7:0] load_byte_c;

   assign run_c = (state_q != IDLE);

   pcm_bit_timer #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_bit_timer (
      .clk           (clk),
      .reset         (reset),
      .run_i         (run_c),
      .bit_start_c_o (bit_start_c),
      .bit_end_c_o   (bit_end_c)
   );

   // bit_cnt_q is the frame index of the bit currently launched or on the line
   assign accept_c    = in_valid && in_ready_q;
   assign boundary_c  = bit_start_c && (state_q == DATA) && (bit_cnt_q[2:0] == 3'd0);
   assign last_bit_c  = (bit_cnt_q == BCW'(FRAME_BITS - 1));
   assign last_sync_c = (bit_cnt_q == BCW'(SYNC_BITS - 1));
   assign load_byte_c = hold_full_q ? hold_q : FILL_BYTE;

   always_comb begin
      state_d       = state_q;
      bit_cnt_d     = bit_cnt_q;
      shift_d       = shift_q;
      hold_d        = hold_q;
      hold_full_d   = hold_full_q;
      txd_d         = txd_q;
      frame_start_d = 1'b0;
      frame_count_d = frame_count_q;
      underrun_d    = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (enable) begin
               state_d   = SYNC;
               bit_cnt_d = '0;
               shift_d   = SYNC_WORD;
            end
         end
         SYNC, DATA: begin
            if (bit_start_c) begin
               if (boundary_c) begin
                  txd_d      = load_byte_c[7];
                  shift_d    = {load_byte_c[6:0], 25'd0};
                  underrun_d = !hold_full_q;
               end else begin
                  txd_d   = shift_q[31];
                  shift_d = {shift_q[30:0], 1'b0};
               end
               frame_start_d = (state_q == SYNC) && (bit_cnt_q == '0);
            end
            // Frame ends only after the last bit has been held for its full period
            if (bit_end_c) begin
               if (last_bit_c) begin
                  frame_count_d = frame_count_q + 8'd1;
                  bit_cnt_d     = '0;
                  shift_d       = SYNC_WORD;
                  if (enable) begin
                     state_d = SYNC;
                  end else begin
                     state_d = IDLE;
                     txd_d   = 1'b0;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + BCW'(1);
                  if ((state_q == SYNC) && last_sync_c) begin
                     state_d = DATA;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // A byte accepted on a boundary clk is kept for the following word
      if (boundary_c && hold_full_q) begin
         hold_full_d = 1'b0;
      end
      if (accept_c) begin
         hold_d      = in_data;
         hold_full_d = 1'b1;
      end
      in_ready_d = !hold_full_d;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= IDLE;
         bit_cnt_q     <= '0;
         shift_q       <= '0;
         hold_q        <= '0;
         hold_full_q   <= 1'b0;
         in_ready_q    <= 1'b1;
         txd_q         <= 1'b0;
         frame_start_q <= 1'b0;
         frame_count_q <= '0;
         underrun_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         bit_cnt_q     <= bit_cnt_d;
         shift_q       <= shift_d;
         hold_q        <= hold_d;
         hold_full_q   <= hold_full_d;
         in_ready_q    <= in_ready_d;
         txd_q         <= txd_d;
         frame_start_q <= frame_start_d;
         frame_count_q <= frame_count_d;
         underrun_q    <= underrun_d;
      end
   end

   assign in_ready    = in_ready_q;
   assign txd         = txd_q;
   assign frame_start = frame_start_q;
   assign frame_count = frame_count_q;
   assign underrun    = underrun_q;

endmodule

// File: tb/tb_pcm_nrz_frame_gen.sv
// Bench for pcm_nrz_frame_gen with a short frame (8 words, 4 clks/bit) so several frames fit in a short run.
// A frame-position reference model is compared against the DUT outputs on every clk.
module tb_pcm_nrz_frame_gen;
   import pcm_pkg::*;

   localparam int unsigned CPB        = 4;
   localparam int unsigned WPF        = 8;
   localparam int unsigned FRAME_BITS = WPF * 8;
   localparam int unsigned FRAME_CLKS = FRAME_BITS * CPB;
   localparam logic [7:0]  FILL       = FILL_BYTE_DEF;

   logic       clk;
   logic       reset;
   logic       enable;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;
   logic       txd;
   logic       frame_start;
   logic [7:0] frame_count;
   logic       underrun;

   pcm_nrz_frame_gen #(
      .CLKS_PER_BIT    (CPB),
      .WORDS_PER_FRAME (WPF),
      .SYNC_WORD       (SYNC_WORD_DEF),
      .FILL_BYTE       (FILL)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .enable      (enable),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .txd         (txd),
      .frame_start (frame_start),
      .frame_count (frame_count),
      .underrun    (underrun)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference model: position within the frame decides every output
   logic [31:0] sw = SYNC_WORD_DEF;
   bit          m_active = 1'b0;
   int          m_pos = 0;
   logic        m_txd = 1'b0, m_fs = 1'b0, m_ur = 1'b0, m_rdy = 1'b1;
   logic [7:0]  m_cnt = 8'd0, m_byte = 8'd0;
   logic [7:0]  m_hold[$];

   always @(posedge clk) begin : ref_model
      int n, k;
      logic acc;
      logic [7:0] acc_byte;
      if (reset) begin
         m_active = 1'b0; m_pos = 0; m_hold.delete();
         m_txd = 1'b0; m_fs = 1'b0; m_ur = 1'b0; m_cnt = 8'd0; m_rdy = 1'b1;
      end else begin
         acc = in_valid && m_rdy;
         acc_byte = in_data;
         m_fs = 1'b0;
         m_ur = 1'b0;
         if (m_active) begin
            n = m_pos / CPB;
            if (m_pos % CPB == 0) begin
               if (n < 32) begin
                  m_txd = sw[31-n];
                  m_fs  = (n == 0);
               end else begin
                  k = (n - 32) % 8;
                  if (k == 0) begin
                     if (m_hold.size() > 0) m_byte = m_hold.pop_front();
                     else begin m_byte = FILL; m_ur = 1'b1; end
                  end
                  m_txd = m_byte[7-k];
               end
            end
            if (m_pos == FRAME_CLKS - 1) begin
               m_cnt = m_cnt + 8'd1;
               m_pos = 0;
               if (!enable) begin m_active = 1'b0; m_txd = 1'b0; end
            end else begin
               m_pos++;
            end
         end else if (enable) begin
            m_active = 1'b1;
            m_pos = 0;
         end
         if (acc) m_hold.push_back(acc_byte);
         m_rdy = (m_hold.size() == 0);
      end
   end

   int   total = 0;
   int   bad = 0;
   int   fs_cnt = 0;
   int   ur_cnt = 0;
   int   mode = 0;        // 0 quiet, 1 back-to-back counting producer, 2 random producer
   logic acc_pend = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick(input int n);
      logic [11:0] act_v, exp_v;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         exp_v = {m_txd, m_fs, m_ur, m_rdy, m_cnt};
         act_v = {txd, frame_start, underrun, in_ready, frame_count};
         total++;
         if (act_v !== exp_v) begin
            bad++;
            $display("FAIL cycle t=%0t {txd,fs,ur,rdy,cnt} got %03h want %03h", $time, act_v, exp_v);
         end
         if (frame_start === 1'b1) fs_cnt++;
         if (underrun === 1'b1) ur_cnt++;
         #1;
         case (mode)
            1: begin
               if (acc_pend) in_data = in_data + 8'd1;
               in_valid = 1'b1;
            end
            2: begin
               in_valid = ($urandom_range(0, 2) == 0);
               in_data  = 8'($urandom);
            end
            default: ;
         endcase
         acc_pend = in_valid && in_ready;
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      enable = 1'b0;
      in_valid = 1'b0;
      mode = 0;
      acc_pend = 1'b0;
      tick(2);
      reset = 1'b0;
   endtask

   typedef struct {
      bit stream;
      int drop;
      int exp_frames;
      int exp_ur;
   } vec_t;

   vec_t        tbl[4];
   int          fs1, fs2;
   logic [31:0] rx;
   logic [7:0]  rx_byte;

   initial begin
      tbl[0] = '{1'b0, 20,  1, 4};
      tbl[1] = '{1'b1, 20,  1, 0};
      tbl[2] = '{1'b0, 600, 3, 12};
      tbl[3] = '{1'b1, 300, 2, 0};

      reset = 1'b1;
      enable = 1'b1;
      in_valid = 1'b0;
      in_data = 8'h00;

      // Reset held with enable high
      fs_cnt = 0;
      tick(5);
      check("rst_txd", 32'(txd), 32'd0);
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_frame_count", 32'(frame_count), 32'd0);
      check("rst_no_frame_start", 32'(fs_cnt), 32'd0);

      // Release with enable high and no data: sync word, period, then reset mid-frame
      reset = 1'b0;
      fs1 = -1; fs2 = -1; rx = '0;
      for (int cyc = 1; cyc <= 278; cyc++) begin
         tick(1);
         if (frame_start === 1'b1) begin
            if (fs1 < 0) fs1 = cyc; else if (fs2 < 0) fs2 = cyc;
         end
         if (cyc == 2) check("first_frame_start", 32'(frame_start), 32'd1);
         if (cyc >= 2 && cyc < 2 + 32 * CPB && (cyc - 2) % CPB == 0) rx = {rx[30:0], txd};
         if (cyc == 258) check("frame_count_after_1", 32'(frame_count), 32'd1);
         if (cyc == 270) begin in_valid = 1'b1; in_data = 8'h5A; end
         if (cyc == 271) in_valid = 1'b0;
         if (cyc == 277) check("held_before_reset", 32'(in_ready), 32'd0);
      end
      check("sync_word", rx, SYNC_WORD_DEF);
      check("frame_start_period", 32'(fs2 - fs1), 32'(FRAME_CLKS));
      check("txd_before_reset", 32'(txd), 32'd1);
      reset = 1'b1;
      #1;
      check("mid_reset_txd", 32'(txd), 32'd0);
      check("mid_reset_in_ready", 32'(in_ready), 32'd1);
      check("mid_reset_frame_count", 32'(frame_count), 32'd0);
      tick(2);
      reset = 1'b0;
      ur_cnt = 0; fs_cnt = 0;
      tick(20);
      enable = 1'b0;
      tick(300);
      check("after_reset_underruns", 32'(ur_cnt), 32'd4);
      check("after_reset_frames", 32'(fs_cnt), 32'd1);

      // Byte pre-loaded in IDLE goes out as the first data word
      do_reset();
      in_valid = 1'b1; in_data = 8'hA5;
      tick(1);
      in_valid = 1'b0;
      tick(2);
      check("preload_in_ready", 32'(in_ready), 32'd0);
      enable = 1'b1;
      rx_byte = '0;
      for (int cyc = 1; cyc <= 170; cyc++) begin
         tick(1);
         if (cyc == 20) enable = 1'b0;
         if (cyc == 129) check("preload_ready_before_load", 32'(in_ready), 32'd0);
         if (cyc == 130) check("preload_ready_after_load", 32'(in_ready), 32'd1);
         if (cyc >= 2 + 32 * CPB && cyc < 2 + 40 * CPB && (cyc - 2) % CPB == 0)
            rx_byte = {rx_byte[6:0], txd};
      end
      check("preload_byte", 32'(rx_byte), 32'hA5);
      tick(200);

      // Table of whole-run scenarios
      for (int i = 0; i < 4; i++) begin
         do_reset();
         if (tbl[i].stream) begin in_data = 8'h00; mode = 1; end
         tick(3);
         ur_cnt = 0; fs_cnt = 0;
         enable = 1'b1;
         tick(tbl[i].drop);
         enable = 1'b0;
         tick(400);
         mode = 0; in_valid = 1'b0; acc_pend = 1'b0;
         check($sformatf("vec%0d_frames", i), 32'(fs_cnt), 32'(tbl[i].exp_frames));
         check($sformatf("vec%0d_underruns", i), 32'(ur_cnt), 32'(tbl[i].exp_ur));
         check($sformatf("vec%0d_frame_count", i), 32'(frame_count), 32'(tbl[i].exp_frames));
         check($sformatf("vec%0d_idle_txd", i), 32'(txd), 32'd0);
      end

      // Random producer, enable and occasional reset against the model
      do_reset();
      mode = 2;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 99) == 0) enable = ~enable;
         reset = ($urandom_range(0, 999) == 0);
         tick(1);
      end
      mode = 0;
      do_reset();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
